// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter
// APB master shared by NUM_REQ requesters under round-robin arbitration.
// Each granted command runs one SETUP cycle and an ACCESS phase that lasts
// until PREADY. Completion is reported per requester with done_o and rdata_o.
// Optional feature macro: APB_ARB_TIMEOUT_EN enables an ACCESS-phase watchdog
// that aborts a transfer after TMO_CYC cycles without PREADY and flags err_o.
module apb_master_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TMO_CYC = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        req_wr_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        done_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic                      err_o,
  output logic                      m_apb_psel_o,
  output logic                      m_apb_penable_o,
  output logic [ADDR_W-1:0]         m_apb_paddr_o,
  output logic                      m_apb_pwrite_o,
  output logic [DATA_W-1:0]         m_apb_pwdata_o,
  input  logic [DATA_W-1:0]         m_apb_prdata_i,
  input  logic                      m_apb_pready_i
);

  localparam int IDX_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

  // Reject parameter values the arbiter was not built for.
  if (NUM_REQ < 2 || NUM_REQ > 4 || TMO_CYC < 1) begin : g_bad_param
    $error("apb_master_arbiter: NUM_REQ must be 2..4 and TMO_CYC at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic               psel_q, psel_d;
  logic               penable_q, penable_d;
  logic [ADDR_W-1:0]  paddr_q, paddr_d;
  logic               pwrite_q, pwrite_d;
  logic [DATA_W-1:0]  pwdata_q, pwdata_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;

  logic               found;
  logic [IDX_W-1:0]   pick;
  logic [IDX_W-1:0]   cand_idx;
  int                 cand;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TMO_CYC + 1);
  logic [CNT_W-1:0]   tmo_q, tmo_d;
  logic               err_q, err_d;
`endif

  // Round-robin search: first asserted request at or after the pointer, wrapping.
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(rr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && req_i[cand_idx]) begin
        found = 1'b1;
        pick  = cand_idx;
      end
    end
  end

  // Next-state and registered-output logic; the bus registers double as the latched command.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    win_d     = win_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    gnt_d     = '0;
    done_d    = '0;
    rdata_d   = rdata_q;
`ifdef APB_ARB_TIMEOUT_EN
    tmo_d     = tmo_q;
    err_d     = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d     = ST_SETUP;
          win_d       = pick;
          rr_d        = (int'(pick) == NUM_REQ - 1) ? '0 : pick + 1'b1;
          gnt_d[pick] = 1'b1;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          paddr_d     = req_addr_i[int'(pick)*ADDR_W +: ADDR_W];
          pwdata_d    = req_wdata_i[int'(pick)*DATA_W +: DATA_W];
          pwrite_d    = req_wr_i[pick];
        end
      end

      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
        tmo_d     = '0;
`endif
      end

      ST_ACCESS: begin
        if (m_apb_pready_i) begin
          state_d       = ST_IDLE;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          paddr_d       = '0;
          pwrite_d      = 1'b0;
          pwdata_d      = '0;
          done_d[win_q] = 1'b1;
          rdata_d       = pwrite_q ? '0 : m_apb_prdata_i;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (tmo_q == CNT_W'(TMO_CYC - 1)) begin
          state_d       = ST_IDLE;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          paddr_d       = '0;
          pwrite_d      = 1'b0;
          pwdata_d      = '0;
          done_d[win_q] = 1'b1;
          rdata_d       = '0;
          err_d         = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset releases the bus immediately.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      rr_q      <= '0;
      win_q     <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      win_q     <= win_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  // Watchdog counter and abort flag.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign gnt_o           = gnt_q;
  assign done_o          = done_q;
  assign rdata_o         = rdata_q;
  assign m_apb_psel_o    = psel_q;
  assign m_apb_penable_o = penable_q;
  assign m_apb_paddr_o   = paddr_q;
  assign m_apb_pwrite_o  = pwrite_q;
  assign m_apb_pwdata_o  = pwdata_q;

endmodule
